div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle 32-bit integer divider with its own sequencing FSM, serving DIV/DIVU for the EX stage.
//  EX raises start_i with latched operands and holds it; it stalls the pipeline until ready_o.
//  result_o carries {remainder, quotient}; EX forwards it to HI/LO via hi_o/lo_o/whilo_o.
//  annul_i (branch flush or exception) aborts an operation in flight.
// PARAMETERS
//  WIDTH     32  operand width; quotient and remainder are each WIDTH bits
//  CNT_W      6  step-counter width; must hold the value WIDTH
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        reset; synchronous, active-high
//  signed_div_i  in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   WIDTH    dividend; sampled only in IDLE when start_i=1
//  opdata2_i     in   WIDTH    divisor; sampled only in IDLE when start_i=1
//  start_i       in   1        request; EX holds it high until it consumes the result
//  annul_i       in   1        abort current operation
//  result_o      out  2*WIDTH  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
//  ready_o       out  1        result valid (DONE state)
//  busy_o        out  1        1 in BYZERO or RUN
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, working reg=0, result_o=0, ready_o=0, busy_o=0. Applies mid-operation too.
//  Priority per edge: rst > annul_i > FSM transition.
//  States and transitions:
//  - IDLE:   start_i & !annul_i & opdata2_i==0 -> BYZERO
//            start_i & !annul_i & opdata2_i!=0 -> RUN: cnt=0; work={32'b0,|dvd|,1'b0}
//            (65 bits); dsr=|opdata2_i|; register sign flags.
//            |x| = two's-complement negation only if signed_div_i & x[31]; otherwise x unchanged.
//  - BYZERO: next edge -> DONE, result_o=0, ready_o=1. No exception is raised.
//  - RUN:    cnt<32: one restoring step per edge:
//            diff = work[64:32] - {1'b0,dsr} (33-bit).
//            If diff[32]=1: work = work<<1. Else work = {diff[31:0], work[31:0], 1'b1}.
//            cnt++.
//            cnt==32: quotient=work[31:0], remainder=work[64:33].
//            Negate quotient if signed & sign(dvd)!=sign(dsr).
//            Negate remainder if signed & sign(dvd)=1.
//            Load result_o, ready_o=1 -> DONE.
//  - DONE:   hold result_o and ready_o while start_i=1.
//            start_i=0 -> IDLE; result_o=0 and ready_o=0 on that edge.
//  annul_i in BYZERO, RUN or DONE -> IDLE next edge; result_o=0, ready_o=0; no partial result escapes.
//  annul_i in IDLE blocks a start on that edge.
//  Latency: start sampled at edge E0. Nonzero divisor: ready_o high after E33 (34 edges incl. E0).
//  Zero divisor: ready_o high after E1.
//  Operand changes after E0 are ignored until the next IDLE.
//  Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; no trap, no special case.
//  busy_o is a pure decode of state; ready_o and result_o are registered.
// STRUCTURE
//  defines.v holds:
//  - state encodings `DivFree, `DivByZero, `DivOn, `DivEnd (2 bits)
//  - `DivResultReady / `DivResultNotReady, `DivStart / `DivStop
//  - `DoubleRegBus
//  Optional combinational sub-module div_step: {work, dsr} -> next work (one restoring iteration).
//  FSM, counter and sign fix-up stay in div_sequencer.
// TESTING
//  1. DIVU 100/7 -> result_o={32'd2,32'd14}; ready_o rises exactly 34 edges after the start edge.
//  2. DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
//  3. DIVU 5/0 -> BYZERO; ready_o high after 2 edges, result_o=0; busy_o high 1 cycle.
//  4. annul_i pulse at RUN cnt=10 -> IDLE next edge; ready_o stays 0.
//     Then start DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
//  5. DIV 0x80000000/0xFFFFFFFF -> {0,0x80000000}.
//     DIVU same operands -> {0x80000000,0}.
//  6. rst at cnt=20 -> all outputs 0 next edge; hold start_i -> DONE stays until start_i drops;
//     changing opdata during RUN has no effect.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared state encoding and default sizing for the multi-cycle divider.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration on the {partial remainder, dividend/quotient} register.
module div_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] work,
    input  logic [WIDTH-1:0] dsr,
    output logic [2*WIDTH:0] work_next
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff = work[2*WIDTH:WIDTH] - {1'b0, dsr};
        // A borrow means the divisor does not fit: shift in a zero quotient bit.
        if (diff[WIDTH]) begin
            work_next = {work[2*WIDTH-1:0], 1'b0};
        end else begin
            work_next = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequenced 32-step restoring divider for DIV/DIVU; result held until the requester drops start_i.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    div_state_e         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH:0]   work_reg;
    logic [2*WIDTH:0]   work_next;
    logic [WIDTH-1:0]   dsr_reg;
    logic               neg_quot_reg;
    logic               neg_rem_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               ready_reg;

    logic               dvd_neg, dsr_neg;
    logic [WIDTH-1:0]   dvd_abs, dsr_abs;
    logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

    // Magnitudes are taken only for signed operations with a set sign bit.
    always_comb begin
        dvd_neg  = signed_div_i & opdata1_i[WIDTH-1];
        dsr_neg  = signed_div_i & opdata2_i[WIDTH-1];
        dvd_abs  = dvd_neg ? (~opdata1_i + ONE) : opdata1_i;
        dsr_abs  = dsr_neg ? (~opdata2_i + ONE) : opdata2_i;
        quot_raw = work_reg[WIDTH-1:0];
        rem_raw  = work_reg[2*WIDTH:WIDTH+1];
        quot_fix = neg_quot_reg ? (~quot_raw + ONE) : quot_raw;
        rem_fix  = neg_rem_reg ? (~rem_raw + ONE) : rem_raw;
    end

    div_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .work      (work_reg),
        .dsr       (dsr_reg),
        .work_next (work_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= DIV_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (annul_i) begin
            state_next = DIV_FREE;
        end else begin
            case (state_reg)
                DIV_FREE: begin
                    if (start_i) begin
                        state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: state_next = DIV_END;
                DIV_ON: begin
                    if (cnt_reg == STEPS) begin
                        state_next = DIV_END;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state_next = DIV_FREE;
                    end
                end
                default: state_next = DIV_FREE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_reg == DIV_BY_ZERO) || (state_reg == DIV_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            work_reg     <= '0;
            dsr_reg      <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= DIV_RESULT_NOT_READY;
        end else if (annul_i) begin
            // Flush: nothing computed so far may reach the outputs.
            result_reg <= '0;
            ready_reg  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state_reg)
                DIV_FREE: begin
                    if (start_i && (opdata2_i != '0)) begin
                        cnt_reg      <= '0;
                        work_reg     <= {{WIDTH{1'b0}}, dvd_abs, 1'b0};
                        dsr_reg      <= dsr_abs;
                        neg_quot_reg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_reg  <= signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
                DIV_BY_ZERO: begin
                    result_reg <= '0;
                    ready_reg  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (cnt_reg != STEPS) begin
                        work_reg <= work_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                    end else begin
                        result_reg <= {rem_fix, quot_fix};
                        ready_reg  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        result_reg <= '0;
                        ready_reg  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    result_reg <= '0;
                    ready_reg  <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed fix-up, divide-by-zero, annul and reset.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int vectors;
    int miscompares;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start and clock until ready_o (bounded); edges counts the start edge as 1.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cycles);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        busy_cycles  = 0;
        do begin
            tick();
            edges++;
            if (busy_o) busy_cycles++;
        end while (!ready_o && edges < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", ready_o);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy_o);
        end
        vectors++;
        if (result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 0", result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_divu_basic();
        int edges, busy_cycles;
        do_div(1'b0, 32'd100, 32'd7, edges, busy_cycles);
        vectors++;
        if (edges !== 34) begin
            miscompares++;
            $display("FAIL divu_latency: got %0d edges want 34", edges);
        end
        vectors++;
        if (result_o !== {32'd2, 32'd14}) begin
            miscompares++;
            $display("FAIL divu_100_7: got %h want %h", result_o, {32'd2, 32'd14});
        end
        vectors++;
        if (busy_cycles !== 33 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL divu_busy: got %0d cycles (now %b) want 33 (now 0)", busy_cycles, busy_o);
        end
        start_i = 1'b0;
        tick();
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL divu_release: got ready %b result %h want 0 0", ready_o, result_o);
        end
    endtask

    task automatic test_div_signed();
        int edges, busy_cycles;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, edges, busy_cycles);
        vectors++;
        if (result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            miscompares++;
            $display("FAIL div_m7_2: got %h want ffffffff_fffffffd", result_o);
        end
        start_i = 1'b0;
        tick();
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, edges, busy_cycles);
        vectors++;
        if (result_o !== {32'd1, 32'hFFFF_FFFD}) begin
            miscompares++;
            $display("FAIL div_7_m2: got %h want 00000001_fffffffd", result_o);
        end
        vectors++;
        if (edges !== 34) begin
            miscompares++;
            $display("FAIL div_signed_latency: got %0d edges want 34", edges);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_div_by_zero();
        int edges, busy_cycles;
        do_div(1'b0, 32'd5, 32'd0, edges, busy_cycles);
        vectors++;
        if (edges !== 2) begin
            miscompares++;
            $display("FAIL byzero_latency: got %0d edges want 2", edges);
        end
        vectors++;
        if (result_o !== 64'd0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL byzero_result: got ready %b result %h want 1 0", ready_o, result_o);
        end
        vectors++;
        if (busy_cycles !== 1) begin
            miscompares++;
            $display("FAIL byzero_busy: got %0d cycles want 1", busy_cycles);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_annul();
        int edges, busy_cycles;
        int ready_seen;
        // annul in IDLE must block the start on that edge
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        tick();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL annul_idle_block: got busy %b want 0", busy_o);
        end
        annul_i = 1'b0;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL annul_run: got busy %b ready %b want 0 0", busy_o, ready_o);
        end
        ready_seen = 0;
        repeat (30) begin
            tick();
            if (ready_o) ready_seen++;
        end
        vectors++;
        if (ready_seen !== 0 || result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL annul_no_result: got %0d ready cycles result %h want 0 0", ready_seen, result_o);
        end
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, edges, busy_cycles);
        vectors++;
        if (result_o !== {32'd0, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL divu_ffffffff_1: got %h want 00000000_ffffffff", result_o);
        end
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL annul_done: got ready %b result %h want 0 0", ready_o, result_o);
        end
        tick();
    endtask

    task automatic test_overflow();
        int edges, busy_cycles;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cycles);
        vectors++;
        if (result_o !== {32'd0, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL div_min_m1: got %h want 00000000_80000000", result_o);
        end
        start_i = 1'b0;
        tick();
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cycles);
        vectors++;
        if (result_o !== {32'h8000_0000, 32'd0}) begin
            miscompares++;
            $display("FAIL divu_min_m1: got %h want 80000000_00000000", result_o);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int edges;
        int lost;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd10;
        start_i      = 1'b1;
        tick();
        repeat (20) tick();
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got ready %b busy %b result %h want 0 0 0", ready_o, busy_o, result_o);
        end
        // restart with start held; operands changed after the start edge must be ignored
        opdata1_i = 32'd1000;
        opdata2_i = 32'd10;
        tick();
        edges = 1;
        opdata1_i = 32'd77;
        opdata2_i = 32'd3;
        signed_div_i = 1'b1;
        while (!ready_o && edges < 100) begin
            tick();
            edges++;
        end
        vectors++;
        if (edges !== 34 || result_o !== {32'd0, 32'd100}) begin
            miscompares++;
            $display("FAIL opdata_ignored: got %0d edges result %h want 34 00000000_00000064", edges, result_o);
        end
        lost = 0;
        repeat (5) begin
            tick();
            if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd100}) lost++;
        end
        vectors++;
        if (lost !== 0) begin
            miscompares++;
            $display("FAIL done_hold: got %0d bad cycles want 0", lost);
        end
        start_i = 1'b0;
        tick();
        vectors++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            miscompares++;
            $display("FAIL done_release: got ready %b result %h want 0 0", ready_o, result_o);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_by_zero();
        test_annul();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
